// File: rtl/sccb_reg_sequencer.sv
// Register-script sequencer for image-sensor bring-up over an I2C/SCCB master.
// Optional readback-after-write checking is enabled by defining SCCB_SEQ_WRITE_VERIFY_EN.
module sccb_reg_sequencer #(
  parameter int unsigned CLK_FREQ_MHZ = 50,
  parameter logic [6:0]  DEV_ADDR     = 7'h60,
  parameter int unsigned ADDR_BYTES   = 2,
  parameter int unsigned DATA_BYTES   = 1,
  parameter int unsigned SCRIPT_DEPTH = 128,
  parameter int unsigned MAX_RETRIES  = 3,
  localparam int unsigned IDX_W = $clog2(SCRIPT_DEPTH),
  localparam int unsigned AW    = 8 * ADDR_BYTES,
  localparam int unsigned DW    = 8 * DATA_BYTES,
  localparam int unsigned EW    = 2 + AW + DW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [2:0]       o_err_code,
  output logic [IDX_W-1:0] o_err_index,
  output logic [IDX_W-1:0] o_rom_addr,
  input  logic [EW-1:0]    i_rom_data,
  output logic             o_cmd_valid,
  input  logic             i_cmd_ready,
  output logic             o_cmd_read,
  output logic [6:0]       o_cmd_dev_addr,
  output logic [AW-1:0]    o_cmd_reg_addr,
  output logic [DW-1:0]    o_cmd_wdata,
  input  logic             i_rsp_valid,
  input  logic             i_rsp_nack,
  input  logic             i_rsp_arb_lost,
  input  logic [DW-1:0]    i_rsp_rdata
);

  localparam int unsigned TICK = CLK_FREQ_MHZ * 1000;
  localparam int unsigned TW   = $clog2(TICK + 1);
  localparam int unsigned RW   = $clog2(MAX_RETRIES + 2);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_DELAY = 2'd2;

  localparam logic [2:0] ERR_NACK   = 3'd1;
  localparam logic [2:0] ERR_ARB    = 3'd2;
  localparam logic [2:0] ERR_VERIFY = 3'd3;
  localparam logic [2:0] ERR_ABORT  = 3'd4;
  localparam logic [2:0] ERR_OVF    = 3'd5;

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, ISSUE, WAIT_RSP, DELAY, FINISH
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rom_addr_q, rom_addr_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic [DW-1:0]    ms_q, ms_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic             cmd_read_q, cmd_read_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [IDX_W-1:0] err_index_q, err_index_d;
  logic             abort_pend_q, abort_pend_d;

  logic [1:0]       ent_op;
  logic [AW-1:0]    ent_addr;
  logic [DW-1:0]    ent_data;
  logic [IDX_W:0]   idx_inc;
  logic             err_set;
  logic [2:0]       err_val;
  logic             advance;

  assign ent_op   = i_rom_data[EW-1 -: 2];
  assign ent_addr = i_rom_data[DW +: AW];
  assign ent_data = i_rom_data[DW-1:0];
  assign idx_inc  = {1'b0, idx_q} + (IDX_W+1)'(1);

  // Next-state and output logic; failures and index advance are resolved at the end.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rom_addr_d   = rom_addr_q;
    retry_d      = retry_q;
    addr_d       = addr_q;
    data_d       = data_q;
    ms_d         = ms_q;
    tick_d       = tick_q;
    cmd_read_d   = cmd_read_q;
    cmd_valid_d  = cmd_valid_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    err_code_d   = err_code_q;
    err_index_d  = err_index_q;
    abort_pend_d = abort_pend_q;
    err_set      = 1'b0;
    err_val      = 3'd0;
    advance      = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          done_d       = 1'b0;
          error_d      = 1'b0;
          err_code_d   = 3'd0;
          idx_d        = '0;
          rom_addr_d   = '0;
          retry_d      = '0;
          abort_pend_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = FETCH;
        end
      end

      FETCH: begin
        if (i_abort) begin
          err_set = 1'b1;
          err_val = ERR_ABORT;
        end else begin
          state_d = LATCH;
        end
      end

      LATCH: begin
        if (i_abort) begin
          err_set = 1'b1;
          err_val = ERR_ABORT;
        end else begin
          addr_d     = ent_addr;
          data_d     = ent_data;
          cmd_read_d = (ent_op == OP_READ);
          retry_d    = '0;
          case (ent_op)
            OP_WRITE, OP_READ: begin
              cmd_valid_d = 1'b1;
              state_d     = ISSUE;
            end
            OP_DELAY: begin
              ms_d    = ent_data;
              tick_d  = '0;
              state_d = DELAY;
            end
            default: begin
              done_d  = 1'b1;
              state_d = FINISH;
            end
          endcase
        end
      end

      ISSUE: begin
        // A handshake in the same cycle as abort wins; the abort waits for the response.
        if (cmd_valid_q && i_cmd_ready) begin
          cmd_valid_d  = 1'b0;
          abort_pend_d = i_abort;
          state_d      = WAIT_RSP;
        end else if (i_abort) begin
          err_set = 1'b1;
          err_val = ERR_ABORT;
        end
      end

      WAIT_RSP: begin
        abort_pend_d = abort_pend_q | i_abort;
        if (i_rsp_valid) begin
          abort_pend_d = 1'b0;
          if (abort_pend_q || i_abort) begin
            err_set = 1'b1;
            err_val = ERR_ABORT;
          end else if (i_rsp_nack || i_rsp_arb_lost) begin
            if (retry_q < RW'(MAX_RETRIES)) begin
              retry_d     = retry_q + RW'(1);
              cmd_valid_d = 1'b1;
              state_d     = ISSUE;
            end else begin
              err_set = 1'b1;
              err_val = i_rsp_nack ? ERR_NACK : ERR_ARB;
            end
          end else if (cmd_read_q && (i_rsp_rdata != data_q)) begin
            err_set = 1'b1;
            err_val = ERR_VERIFY;
`ifdef SCCB_SEQ_WRITE_VERIFY_EN
          end else if (!cmd_read_q) begin
            // Readback of the just-written register; keeps the entry's retry count.
            cmd_read_d  = 1'b1;
            cmd_valid_d = 1'b1;
            state_d     = ISSUE;
`endif
          end else begin
            retry_d = '0;
            advance = 1'b1;
          end
        end
      end

      DELAY: begin
        if (i_abort) begin
          err_set = 1'b1;
          err_val = ERR_ABORT;
        end else if (ms_q == '0) begin
          advance = 1'b1;
        end else if (tick_q == TW'(TICK - 1)) begin
          tick_d = '0;
          ms_d   = ms_q - DW'(1);
          if (ms_q == DW'(1)) begin
            advance = 1'b1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Running off the end of the script without END is an error.
    if (advance) begin
      if (idx_inc == (IDX_W+1)'(SCRIPT_DEPTH)) begin
        err_set = 1'b1;
        err_val = ERR_OVF;
      end else begin
        idx_d      = idx_q + IDX_W'(1);
        rom_addr_d = idx_q + IDX_W'(1);
        state_d    = FETCH;
      end
    end

    if (err_set) begin
      error_d     = 1'b1;
      err_code_d  = err_val;
      err_index_d = idx_q;
      cmd_valid_d = 1'b0;
      state_d     = FINISH;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rom_addr_q   <= '0;
      retry_q      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      ms_q         <= '0;
      tick_q       <= '0;
      cmd_read_q   <= 1'b0;
      cmd_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 3'd0;
      err_index_q  <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rom_addr_q   <= rom_addr_d;
      retry_q      <= retry_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      ms_q         <= ms_d;
      tick_q       <= tick_d;
      cmd_read_q   <= cmd_read_d;
      cmd_valid_q  <= cmd_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      err_index_q  <= err_index_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_error        = error_q;
  assign o_err_code     = err_code_q;
  assign o_err_index    = err_index_q;
  assign o_rom_addr     = rom_addr_q;
  assign o_cmd_valid    = cmd_valid_q;
  assign o_cmd_read     = cmd_read_q;
  assign o_cmd_dev_addr = DEV_ADDR;
  assign o_cmd_reg_addr = addr_q;
  assign o_cmd_wdata    = data_q;

endmodule
